gzip_block_sequencer: RTL and testbench
=======================================

Name: gzip_block_sequencer

Overview:
- Front-end controller between the 32-bit input FIFO and the LZ77/Huffman byte datapath of gzip_top.
- Pops a block header word, then unpacks the following data words into a byte stream with valid/ready handshake.
- Tags the stream with block start/last, BFINAL and BTYPE, and waits for the encoder to flush before starting the next block.
- Stops after the block carrying BFINAL=1.

Parameters:
- DATA_WIDTH, 8, byte width to datapath
- WORD_WIDTH, 32, input FIFO word width (fixed 4 bytes/word)
- LEN_WIDTH, 24, block length field width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btype_in  in  2  block type from host register, sampled at header latch
- empty_in_fifo  in  1  input FIFO empty
- dout_in_fifo  in  32  input FIFO read data, valid the cycle after rd_en_fifo_in
- rd_en_fifo_in  out  1  input FIFO pop strobe
- byte_out  out  8  data byte to LZ77 engine
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  engine accepts byte
- block_start  out  1  one-cycle pulse, header accepted
- block_last  out  1  high with the final byte of a block
- bfinal_out  out  1  BFINAL of current block
- btype_out  out  2  BTYPE of current block
- block_done_in  in  1  encoder finished flushing current block
- err_len  out  1  one-cycle pulse, zero-length header discarded
- busy  out  1  not in IDLE/DONE
- stream_done  out  1  final block completed

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Reset asserted mid-block aborts immediately; no partial bytes are emitted afterwards.
- Header word layout (host byte-swapped):
  - BFINAL = word[0].
  - LENGTH = {word[15:8], word[23:16], word[31:24]}.
- Data word byte order: word[7:0] first, then [15:8], [23:16], [31:24].
- FSM states: IDLE, HDR_RD, HDR_LAT, WORD_RD, WORD_LAT, SEND, WAIT_DONE, DONE.
- IDLE: if !empty_in_fifo, assert rd_en_fifo_in for 1 cycle and go to HDR_RD.
- HDR_RD: 1 cycle for FIFO read latency, then HDR_LAT.
- HDR_LAT:
  - Latch bfinal_out, btype_out (from btype_in) and remaining=LENGTH.
  - LENGTH==0: pulse err_len, return to IDLE.
  - Otherwise pulse block_start and go to WORD_RD, which pops the next word once !empty_in_fifo.
- WORD_RD / WORD_LAT: pop the word, latch it, set byte index=0, go to SEND.
- SEND:
  - byte_valid=1 and byte_out=selected byte. Byte, valid and last stay stable until byte_ready.
  - On byte_valid&&byte_ready: remaining-=1 and index+=1.
  - block_last=1 while remaining==1.
  - When remaining reaches 0, go to WAIT_DONE. Unsent bytes of the current word are padding and are discarded.
  - If index wraps past 3 with remaining>0, go to WORD_RD.
- FIFO empty in WORD_RD: stall with byte_valid=0. No timeout.
- WAIT_DONE: on block_done_in, go to DONE if bfinal_out, else IDLE. block_done_in is ignored in all other states.
- DONE: stream_done=1, FIFO no longer popped; held until reset.
- Throughput: 1 byte/cycle in SEND with byte_ready held high; 2 bubble cycles per word fetch.
- Only one FIFO pop is outstanding at a time. rd_en_fifo_in is never asserted while empty_in_fifo=1.

Optional Feature:
- Macro: GZIP_SEQ_HDR_BTYPE_EN.
- Defined: btype_out is taken from header word[2:1] and btype_in is unused.
- Undefined: btype_out = btype_in sampled in HDR_LAT. btype_in changes mid-block do not affect btype_out.

Decomposition:
- Package gzip_pkg holds:
  - FSM state enum.
  - BTYPE constants: NO_COMPRESSION=2'b00, FIXED_HUFFMAN=2'b01.
  - Header field position constants.
  - A header-decode function (swap → bfinal, btype, length).
- Natural sub-module: gzip_word_unpacker, which holds the latched word plus the byte index and provides byte select with valid/ready.
- The FSM and length counter stay in the top.

Test Plan:
- Header 0x1D000001 followed by 8 words "That apple is our best apple." with byte_ready=1 → block_start pulse, bfinal_out=1, exactly 29 bytes in order, block_last on '.', 3 pad bytes dropped; after block_done_in, stream_done=1.
- Two blocks, LENGTH=5 with BFINAL=0 then LENGTH=3 with BFINAL=1 → second block_start only after block_done_in; 8 bytes total; stream_done only after the second done.
- byte_ready toggled randomly (50%) → byte_out/byte_valid/block_last stable while stalled; no byte lost or duplicated.
- Header 0x00000000 → err_len pulse, no byte_valid; next valid header is processed normally.
- FIFO empty gap of 10 cycles mid-block → byte_valid=0 during the gap, no rd_en while empty, stream resumes correctly.
- rst_n asserted in SEND after 2 of 4 bytes → all outputs 0 asynchronously; after release, the FSM is IDLE and the next header starts a new block.

Source files
------------

// File: rtl/gzip_pkg.sv
// Shared types and header decode for the gzip block sequencer.
// Header BTYPE is only consumed when GZIP_SEQ_HDR_BTYPE_EN is defined.
package gzip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_RD,
    HDR_LAT,
    WORD_RD,
    WORD_LAT,
    SEND,
    WAIT_DONE,
    DONE
  } seq_state_e;

  localparam logic [1:0] NO_COMPRESSION = 2'b00;
  localparam logic [1:0] FIXED_HUFFMAN  = 2'b01;

  localparam int HDR_WORD_W    = 32;
  localparam int HDR_LEN_W     = 24;
  localparam int HDR_BFINAL_BIT = 0;
  localparam int HDR_BTYPE_LSB  = 1;

  typedef struct packed {
    logic                 bfinal;
    logic [1:0]           btype;
    logic [HDR_LEN_W-1:0] length;
  } hdr_t;

  // The host writes the length big-endian into the upper three bytes.
  function automatic hdr_t hdr_decode(input logic [HDR_WORD_W-1:0] w);
    hdr_t h;
    h.bfinal = w[HDR_BFINAL_BIT];
    h.btype  = w[HDR_BTYPE_LSB +: 2];
    h.length = {w[15:8], w[23:16], w[31:24]};
    return h;
  endfunction

endpackage

// File: rtl/gzip_word_unpacker.sv
// Holds one FIFO word and presents its bytes, lowest lane first, under
// a valid/ready handshake; the index advances only on an accepted byte.
module gzip_word_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  active,
  input  logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  byte_fire,
  output logic                  lane_last
);

  localparam int LANES = WORD_WIDTH / DATA_WIDTH;
  localparam int IDX_W = $clog2(LANES);

  logic [WORD_WIDTH-1:0] word_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DATA_WIDTH-1:0] lane [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane[gi] = word_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign byte_valid = active;
  assign byte_fire  = active && byte_ready;
  assign byte_out   = active ? lane[idx_reg] : '0;
  assign lane_last  = (idx_reg == IDX_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (load) begin
      word_reg <= word_in;
      idx_reg  <= '0;
    end else if (byte_fire) begin
      idx_reg  <= idx_reg + IDX_W'(1);
    end
  end

endmodule

// File: rtl/gzip_block_sequencer.sv
// Block front-end: pops header and data words, streams bytes tagged per block.
// GZIP_SEQ_HDR_BTYPE_EN: take BTYPE from header bits [2:1] instead of btype_in.
module gzip_block_sequencer
  import gzip_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            btype_in,
  input  logic                  empty_in_fifo,
  input  logic [WORD_WIDTH-1:0] dout_in_fifo,
  output logic                  rd_en_fifo_in,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  block_start,
  output logic                  block_last,
  output logic                  bfinal_out,
  output logic [1:0]            btype_out,
  input  logic                  block_done_in,
  output logic                  err_len,
  output logic                  busy,
  output logic                  stream_done
);

  seq_state_e           state_reg, state_next;
  logic [LEN_WIDTH-1:0] remaining_reg, remaining_next;
  logic                 bfinal_reg, bfinal_next;
  logic [1:0]           btype_reg, btype_next;
  logic                 block_start_reg, block_start_next;
  logic                 err_len_reg, err_len_next;
  logic                 pop_req, load_word, byte_fire, lane_last;
  logic                 unused_hdr;
  hdr_t                 hdr;

  assign hdr = hdr_decode(dout_in_fifo);

`ifdef GZIP_SEQ_HDR_BTYPE_EN
  assign unused_hdr = ^{btype_in};
`else
  assign unused_hdr = ^{hdr.btype};
`endif

  gzip_word_unpacker #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_word),
    .word_in   (dout_in_fifo),
    .active    (state_reg == SEND),
    .byte_ready(byte_ready),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .byte_fire (byte_fire),
    .lane_last (lane_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      remaining_reg   <= '0;
      bfinal_reg      <= 1'b0;
      btype_reg       <= 2'b00;
      block_start_reg <= 1'b0;
      err_len_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      remaining_reg   <= remaining_next;
      bfinal_reg      <= bfinal_next;
      btype_reg       <= btype_next;
      block_start_reg <= block_start_next;
      err_len_reg     <= err_len_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    remaining_next   = remaining_reg;
    bfinal_next      = bfinal_reg;
    btype_next       = btype_reg;
    block_start_next = 1'b0;
    err_len_next     = 1'b0;
    pop_req          = 1'b0;
    load_word        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_in_fifo) begin
          pop_req    = 1'b1;
          state_next = HDR_RD;
        end
      end
      HDR_RD: state_next = HDR_LAT;
      HDR_LAT: begin
        bfinal_next    = hdr.bfinal;
`ifdef GZIP_SEQ_HDR_BTYPE_EN
        btype_next     = hdr.btype;
`else
        btype_next     = btype_in;
`endif
        remaining_next = LEN_WIDTH'(hdr.length);
        if (hdr.length == '0) begin
          err_len_next = 1'b1;
          state_next   = IDLE;
        end else begin
          block_start_next = 1'b1;
          state_next       = WORD_RD;
        end
      end
      WORD_RD: begin
        if (!empty_in_fifo) begin
          pop_req    = 1'b1;
          state_next = WORD_LAT;
        end
      end
      WORD_LAT: begin
        load_word  = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        // Leftover lanes after the final byte are padding and are dropped.
        if (byte_fire) begin
          remaining_next = remaining_reg - LEN_WIDTH'(1);
          if (remaining_reg == LEN_WIDTH'(1)) begin
            state_next = WAIT_DONE;
          end else if (lane_last) begin
            state_next = WORD_RD;
          end
        end
      end
      WAIT_DONE: begin
        if (block_done_in) begin
          state_next = bfinal_reg ? DONE : IDLE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Gate the pop with reset so a non-empty FIFO is never popped during reset.
  assign rd_en_fifo_in = pop_req && rst_n;
  assign block_last    = (state_reg == SEND) && (remaining_reg == LEN_WIDTH'(1));
  assign block_start   = block_start_reg;
  assign err_len       = err_len_reg;
  assign bfinal_out    = bfinal_reg;
  assign btype_out     = btype_reg;
  assign busy          = (state_reg != IDLE) && (state_reg != DONE);
  assign stream_done   = (state_reg == DONE);

endmodule

// File: tb/tb_gzip_block_sequencer.sv
// Directed self-checking bench for gzip_block_sequencer with a small FIFO model.
module tb_gzip_block_sequencer;
  import gzip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  btype_in = FIXED_HUFFMAN;
  logic        empty_in_fifo;
  logic [31:0] dout_in_fifo = '0;
  logic        rd_en_fifo_in;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        block_start, block_last, bfinal_out;
  logic [1:0]  btype_out;
  logic        block_done_in = 1'b0;
  logic        err_len, busy, stream_done;

  int checks = 0;
  int errors = 0;

  gzip_block_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btype_in     (btype_in),
    .empty_in_fifo(empty_in_fifo),
    .dout_in_fifo (dout_in_fifo),
    .rd_en_fifo_in(rd_en_fifo_in),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .block_start  (block_start),
    .block_last   (block_last),
    .bfinal_out   (bfinal_out),
    .btype_out    (btype_out),
    .block_done_in(block_done_in),
    .err_len      (err_len),
    .busy         (busy),
    .stream_done  (stream_done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, one word per pop.
  logic [31:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty_in_fifo = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en_fifo_in) begin
      dout_in_fifo <= mem[rd_ptr[6:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Observer, sampling on the falling edge.
  logic [7:0] got_byte [0:255];
  logic       got_last [0:255];
  int got_cnt = 0, start_cnt = 0, err_cnt = 0, pop_cnt = 0;
  int stall_viol = 0, rden_viol = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [7:0] prev_b = '0;

  always @(negedge clk) begin
    if (byte_valid && byte_ready) begin
      got_byte[got_cnt[7:0]] = byte_out;
      got_last[got_cnt[7:0]] = block_last;
      got_cnt++;
    end
    if (block_start) start_cnt++;
    if (err_len) err_cnt++;
    if (rd_en_fifo_in) pop_cnt++;
    if (rd_en_fifo_in && empty_in_fifo) rden_viol++;
    if (rst_n && prev_v && !prev_r &&
        (!byte_valid || byte_out !== prev_b || block_last !== prev_l)) stall_viol++;
    prev_v = byte_valid && rst_n;
    prev_r = byte_ready;
    prev_b = byte_out;
    prev_l = block_last;
  end

  logic rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[6:0]] = w;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) byte_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_bytes(input int target, input int budget);
    for (int i = 0; i < budget && got_cnt < target; i++) step();
  endtask

  task automatic pulse_done();
    step();
    block_done_in = 1'b1;
    step();
    block_done_in = 1'b0;
    step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [7:0] exp [],
                           input int last_pos);
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_byte[(base + i) % 256]}, {24'd0, exp[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, got_last[(base + i) % 256]},
          {31'd0, (i == last_pos)});
    end
  endtask

  initial begin
    string       txt;
    logic [7:0]  exp_b [];
    logic [7:0]  c [0:3];
    int          base, sbase, ebase, pbase, vcnt;
    logic [1:0]  exp_btype;

    txt = "That apple is our best apple.";
`ifdef GZIP_SEQ_HDR_BTYPE_EN
    exp_btype = NO_COMPRESSION;
`else
    exp_btype = FIXED_HUFFMAN;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, stream_done}, 32'd0);
    chk("rst_rden", {31'd0, rd_en_fifo_in}, 32'd0);
    chk("rst_bfinal", {31'd0, bfinal_out}, 32'd0);
    rst_n = 1'b1;
    $display("step reset: checked idle outputs");

    // Test 1: single final block of 29 bytes, three pad bytes
    push(32'h1D000001);
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) c[k] = (4*w + k < txt.len()) ? txt[4*w + k] : 8'h00;
      push({c[3], c[2], c[1], c[0]});
    end
    base = got_cnt; sbase = start_cnt; pbase = pop_cnt;
    wait_bytes(base + 10, 200);
    btype_in = 2'b10;
    wait_bytes(base + 29, 200);
    repeat (5) step();
    chk("t1_count", got_cnt - base, 29);
    chk("t1_start", start_cnt - sbase, 1);
    chk("t1_pops", pop_cnt - pbase, 9);
    chk("t1_bfinal", {31'd0, bfinal_out}, 32'd1);
    chk("t1_btype_held", {30'd0, btype_out}, {30'd0, exp_btype});
    chk("t1_done_early", {31'd0, stream_done}, 32'd0);
    exp_b = new[29];
    for (int i = 0; i < 29; i++) exp_b[i] = txt[i];
    chk_bytes("t1", base, exp_b, 28);
    pulse_done();
    chk("t1_stream_done", {31'd0, stream_done}, 32'd1);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    btype_in = FIXED_HUFFMAN;
    // Words queued while DONE must stay in the FIFO
    pbase = pop_cnt;
    push(32'h05000000); push(32'h44434241); push(32'h00000045);
    push(32'h03000001); push(32'h00636261);
    repeat (6) step();
    chk("t1_no_pop_done", pop_cnt - pbase, 0);
    $display("step block29: %0d bytes received", got_cnt - base);

    // Test 2: two blocks, second waits for the first flush
    base = got_cnt; sbase = start_cnt;
    do_reset();
    wait_bytes(base + 5, 100);
    repeat (5) step();
    chk("t2_start_one", start_cnt - sbase, 1);
    chk("t2_hold_count", got_cnt - base, 5);
    chk("t2_busy_wait", {31'd0, busy}, 32'd1);
    pulse_done();
    wait_bytes(base + 8, 100);
    repeat (2) step();
    chk("t2_start_two", start_cnt - sbase, 2);
    chk("t2_count", got_cnt - base, 8);
    chk("t2_done_early", {31'd0, stream_done}, 32'd0);
    pulse_done();
    chk("t2_stream_done", {31'd0, stream_done}, 32'd1);
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    chk_bytes("t2a", base, exp_b, 4);
    exp_b = '{8'h61, 8'h62, 8'h63};
    chk_bytes("t2b", base + 5, exp_b, 2);
    $display("step two_blocks: %0d bytes received", got_cnt - base);

    // Test 3: random back-pressure
    do_reset();
    base = got_cnt;
    push(32'h0A000001); push(32'h13121110); push(32'h17161514); push(32'h00001918);
    rand_ready = 1'b1;
    wait_bytes(base + 10, 400);
    rand_ready = 1'b0;
    byte_ready = 1'b1;
    repeat (3) step();
    chk("t3_count", got_cnt - base, 10);
    chk("t3_stall_stable", stall_viol, 0);
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    chk_bytes("t3", base, exp_b, 9);
    pulse_done();
    chk("t3_stream_done", {31'd0, stream_done}, 32'd1);
    $display("step backpressure: %0d bytes received", got_cnt - base);

    // Test 4: zero-length header discarded
    do_reset();
    base = got_cnt; sbase = start_cnt; ebase = err_cnt;
    push(32'h00000000); push(32'h02000001); push(32'h0000BBAA);
    wait_bytes(base + 2, 100);
    repeat (3) step();
    chk("t4_err_pulse", err_cnt - ebase, 1);
    chk("t4_start", start_cnt - sbase, 1);
    chk("t4_count", got_cnt - base, 2);
    exp_b = '{8'hAA, 8'hBB};
    chk_bytes("t4", base, exp_b, 1);
    pulse_done();
    chk("t4_stream_done", {31'd0, stream_done}, 32'd1);
    $display("step zero_len: err pulses %0d", err_cnt - ebase);

    // Test 5: FIFO runs empty mid-block
    do_reset();
    base = got_cnt;
    push(32'h08000001); push(32'h03020100);
    wait_bytes(base + 4, 100);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (byte_valid) vcnt++;
    end
    chk("t5_gap_valid", vcnt, 0);
    chk("t5_gap_count", got_cnt - base, 4);
    push(32'h07060504);
    wait_bytes(base + 8, 100);
    repeat (2) step();
    chk("t5_count", got_cnt - base, 8);
    chk("t5_rden_empty", rden_viol, 0);
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    chk_bytes("t5", base, exp_b, 7);
    pulse_done();
    chk("t5_stream_done", {31'd0, stream_done}, 32'd1);
    $display("step fifo_gap: %0d bytes received", got_cnt - base);

    // Test 6: asynchronous reset in SEND after two of four bytes
    do_reset();
    base = got_cnt; sbase = start_cnt;
    byte_ready = 1'b0;
    push(32'h04000000); push(32'hDDCCBBAA);
    for (int i = 0; i < 50 && !byte_valid; i++) step();
    chk("t6_in_send", {31'd0, byte_valid}, 32'd1);
    byte_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("t6_rst_byte", {24'd0, byte_out}, 32'd0);
    chk("t6_rst_last", {31'd0, block_last}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_rden", {31'd0, rd_en_fifo_in}, 32'd0);
    chk("t6_rst_start", {31'd0, block_start}, 32'd0);
    chk("t6_rst_btype", {30'd0, btype_out}, 32'd0);
    chk("t6_partial", got_cnt - base, 2);
    exp_b = '{8'hAA, 8'hBB};
    chk_bytes("t6a", base, exp_b, -1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("t6_no_more", got_cnt - base, 2);
    push(32'h02000001); push(32'h0000FFEE);
    wait_bytes(base + 4, 100);
    repeat (2) step();
    chk("t6_count", got_cnt - base, 4);
    chk("t6_start", start_cnt - sbase, 2);
    exp_b = '{8'hEE, 8'hFF};
    chk_bytes("t6b", base + 2, exp_b, 1);
    pulse_done();
    chk("t6_stream_done", {31'd0, stream_done}, 32'd1);
    $display("step async_reset: resumed with %0d bytes", got_cnt - base - 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
